// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Drives a 4-digit common-anode seven-segment display. Each digit holds a
// hex value plus decimal point. The controller multiplexes the digits onto
// shared select and segment pins. Each slot starts with a dead-time blank to
// suppress ghosting. A PWM on-phase follows, and it sets the brightness.
//
// Parameters
//   SLOT_CYCLES  clk cycles per digit slot (>= 8)
//   DEAD_CYCLES  blanked cycles at the start of each slot (< SLOT_CYCLES)
//
// Ports
//   clk, rst_n   clock (rising edge), async active-low reset
//   wr_en        one-cycle write strobe
//   wr_addr      digit index to write (0 = rightmost, io_sel[0])
//   wr_data      {dp, hex[3:0]}
//   digit_en     per-digit enable, 0 blanks that digit's whole slot
//   bright       on-phase duty in eighths (0 = 1/8, 7 = full)
//   frame_tick   one-cycle pulse at the start of each digit-0 slot
//   io_sel       digit select, active-low
//   io_seg       {dp,g,f,e,d,c,b,a}, active-low
//
// Build option
//   SEG_SCAN_DBUF_EN  writes land in a back buffer that is copied to the
//                     displayed buffer at the end of each frame
//
// Slot phases (derived from cnt):
//   phase | meaning
//   DEAD  | cnt < DEAD_CYCLES, all pins blanked
//   ON    | within on_len cycles after DEAD and digit enabled, digit driven
//   OFF   | remainder of slot, all pins blanked
module seg_scan_ctrl #(
    parameter int SLOT_CYCLES = 25000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic [3:0] digit_en,
    input  logic [2:0] bright,
    output logic       frame_tick,
    output logic [3:0] io_sel,
    output logic [7:0] io_seg
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int PW = CW + 3;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [PW-1:0] DEAD_P   = PW'(DEAD_CYCLES);
    localparam logic [PW-1:0] ACTIVE_P = PW'(SLOT_CYCLES - DEAD_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    d;
    logic [4:0]    front [4];
    logic [7:0]    pat_q;
    logic          en_q;
    logic [PW-1:0] on_len_q;

    function automatic logic [7:0] seg_decode(input logic [4:0] v);
        logic [6:0] s;
        case (v[3:0])
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return ~{v[4], s};
    endfunction

    logic          slot_start;
    logic          last_cnt;
    logic [PW-1:0] on_prod;
    logic [PW-1:0] on_len_new;
    logic [7:0]    pat_new;
    logic [7:0]    pat_eff;
    logic          en_eff;
    logic [PW-1:0] on_len_eff;
    logic [PW-1:0] cnt_ext;
    logic [PW-1:0] on_end;
    logic          in_on;

    assign slot_start = (cnt == '0);
    assign last_cnt   = (cnt == CNT_LAST);

    // Product is kept at PW bits; the shift by 3 floors to eighths.
    assign on_prod    = ACTIVE_P * ({{(PW-3){1'b0}}, bright} + PW'(1));
    assign on_len_new = on_prod >> 3;
    assign pat_new    = seg_decode(front[d]);

    // On the slot's first cycle the latched copies are not loaded yet, so use
    // the fresh values directly. This matters only when DEAD_CYCLES is 0.
    assign pat_eff    = slot_start ? pat_new       : pat_q;
    assign en_eff     = slot_start ? digit_en[d]   : en_q;
    assign on_len_eff = slot_start ? on_len_new    : on_len_q;

    assign cnt_ext = {3'b000, cnt};
    assign on_end  = DEAD_P + on_len_eff;
    assign in_on   = en_eff && (cnt_ext >= DEAD_P) && (cnt_ext < on_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            d          <= 2'd0;
            pat_q      <= 8'hFF;
            en_q       <= 1'b0;
            on_len_q   <= '0;
            frame_tick <= 1'b0;
            io_sel     <= 4'hF;
            io_seg     <= 8'hFF;
        end else begin
            cnt <= last_cnt ? '0 : cnt + 1'b1;
            if (last_cnt) d <= d + 1'b1;
            // Slot parameters are frozen here so mid-slot changes never tear.
            if (slot_start) begin
                pat_q    <= pat_new;
                en_q     <= digit_en[d];
                on_len_q <= on_len_new;
            end
            frame_tick <= slot_start && (d == 2'd0);
            io_sel     <= in_on ? ~(4'b0001 << d) : 4'hF;
            io_seg     <= in_on ? pat_eff : 8'hFF;
        end
    end

`ifdef SEG_SCAN_DBUF_EN
    logic [4:0] back [4];
    logic       frame_end;

    assign frame_end = last_cnt && (d == 2'd3);

    // A write in the commit cycle reaches back only. front still takes the
    // old back contents, so that write commits at the next frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                back[i]  <= 5'h00;
                front[i] <= 5'h00;
            end
        end else begin
            if (wr_en) back[wr_addr] <= wr_data;
            if (frame_end) begin
                for (int i = 0; i < 4; i++) front[i] <= back[i];
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) front[i] <= 5'h00;
        end else if (wr_en) begin
            front[wr_addr] <= wr_data;
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [4:0] wr_data;
    logic [3:0] digit_en;
    logic [2:0] bright;
    logic       frame_tick;
    logic [3:0] io_sel;
    logic [7:0] io_seg;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SEG_SCAN_DBUF_EN
    localparam logic [7:0] F1_D2 = 8'hC0;
    localparam logic [7:0] F6_D3 = 8'hC0;
`else
    localparam logic [7:0] F1_D2 = 8'h08;
    localparam logic [7:0] F6_D3 = 8'h40;
`endif

    seg_scan_ctrl #(.SLOT_CYCLES(16), .DEAD_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .digit_en   (digit_en),
        .bright     (bright),
        .frame_tick (frame_tick),
        .io_sel     (io_sel),
        .io_seg     (io_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check_idle(input string tag);
        n_cmp++;
        assert (io_sel === 4'hF) else begin
            n_err++;
            $error("FAIL %s sel: got %h want f", tag, io_sel);
        end
        n_cmp++;
        assert (io_seg === 8'hFF) else begin
            n_err++;
            $error("FAIL %s seg: got %h want ff", tag, io_seg);
        end
        n_cmp++;
        assert (frame_tick === 1'b0) else begin
            n_err++;
            $error("FAIL %s tick: got %b want 0", tag, frame_tick);
        end
    endtask

    // Steps through slot cycles from_c..to_c. Each sample shows the state
    // at slot count i. ON is expected for 2 <= i < 2+n_on.
    task automatic run_slot(input int from_c, input int to_c,
                            input logic [3:0] sel_on, input logic [7:0] seg_on,
                            input int n_on, input logic tick0, input string tag);
        logic       on;
        logic [3:0] e_sel;
        logic [7:0] e_seg;
        logic       e_tick;
        for (int i = from_c; i <= to_c; i++) begin
            @(posedge clk);
            #1;
            wr_en = 1'b0;
            on     = (i >= 2) && (i < 2 + n_on);
            e_sel  = on ? sel_on : 4'hF;
            e_seg  = on ? seg_on : 8'hFF;
            e_tick = (i == 0) ? tick0 : 1'b0;
            n_cmp++;
            assert (io_sel === e_sel) else begin
                n_err++;
                $error("FAIL %s sel c%0d: got %h want %h", tag, i, io_sel, e_sel);
            end
            n_cmp++;
            assert (io_seg === e_seg) else begin
                n_err++;
                $error("FAIL %s seg c%0d: got %h want %h", tag, i, io_seg, e_seg);
            end
            n_cmp++;
            assert (frame_tick === e_tick) else begin
                n_err++;
                $error("FAIL %s tick c%0d: got %b want %b", tag, i, frame_tick, e_tick);
            end
        end
    endtask

    task automatic set_write(input logic [1:0] a, input logic [4:0] v);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = v;
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 2'd0;
        wr_data  = 5'h00;
        digit_en = 4'hF;
        bright   = 3'd7;
        #22;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 0: reset contents show "0" on every digit, full brightness.
        run_slot(0, 15, 4'b1110, 8'hC0, 14, 1'b1, "f0d0");
        run_slot(0, 15, 4'b1101, 8'hC0, 14, 1'b0, "f0d1");
        run_slot(0, 15, 4'b1011, 8'hC0, 14, 1'b0, "f0d2");
        run_slot(0, 15, 4'b0111, 8'hC0, 14, 1'b0, "f0d3");

        // Frame 1: write A with dp to digit 2. Also write 5 to digit 1 while
        // digit 1 is on screen; that write must wait for its next slot.
        set_write(2'd2, 5'h1A);
        run_slot(0, 15, 4'b1110, 8'hC0, 14, 1'b1, "f1d0");
        run_slot(0, 7, 4'b1101, 8'hC0, 14, 1'b0, "f1d1a");
        set_write(2'd1, 5'h05);
        run_slot(8, 15, 4'b1101, 8'hC0, 14, 1'b0, "f1d1b");
        run_slot(0, 15, 4'b1011, F1_D2, 14, 1'b0, "f1d2");
        run_slot(0, 15, 4'b0111, 8'hC0, 14, 1'b0, "f1d3");

        // Frame 2: bright 3 gives 7 ON cycles. Bright drops to 0 mid-slot;
        // the current slot keeps 7 and the next slot gets 1.
        bright = 3'd3;
        run_slot(0, 15, 4'b1110, 8'hC0, 7, 1'b1, "f2d0");
        run_slot(0, 15, 4'b1101, 8'h92, 7, 1'b0, "f2d1");
        run_slot(0, 7, 4'b1011, 8'h08, 7, 1'b0, "f2d2a");
        bright = 3'd0;
        run_slot(8, 15, 4'b1011, 8'h08, 7, 1'b0, "f2d2b");
        run_slot(0, 15, 4'b0111, 8'hC0, 1, 1'b0, "f2d3");

        // Frame 3: digits 1 and 3 disabled.
        bright   = 3'd7;
        digit_en = 4'b0101;
        run_slot(0, 15, 4'b1110, 8'hC0, 14, 1'b1, "f3d0");
        run_slot(0, 15, 4'hF, 8'hFF, 0, 1'b0, "f3d1");
        run_slot(0, 15, 4'b1011, 8'h08, 14, 1'b0, "f3d2");
        run_slot(0, 15, 4'hF, 8'hFF, 0, 1'b0, "f3d3");

        // Frame 4: reset asserted during digit 0's ON phase blanks at once.
        digit_en = 4'hF;
        run_slot(0, 4, 4'b1110, 8'hC0, 14, 1'b1, "f4d0");
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 5: scan restarts at digit 0, buffers back to "0".
        run_slot(0, 15, 4'b1110, 8'hC0, 14, 1'b1, "f5d0");
        run_slot(0, 15, 4'b1101, 8'hC0, 14, 1'b0, "f5d1");
        run_slot(0, 15, 4'b1011, 8'hC0, 14, 1'b0, "f5d2");
        run_slot(0, 15, 4'b0111, 8'hC0, 14, 1'b0, "f5d3");

        // Frame 6: during digit 1, write 7 to digit 0 and "0." to digit 3.
        // Direct mode shows digit 3 this frame. Double-buffered mode holds both
        // writes until after the frame end.
        run_slot(0, 15, 4'b1110, 8'hC0, 14, 1'b1, "f6d0");
        run_slot(0, 4, 4'b1101, 8'hC0, 14, 1'b0, "f6d1a");
        set_write(2'd0, 5'h07);
        run_slot(5, 6, 4'b1101, 8'hC0, 14, 1'b0, "f6d1b");
        set_write(2'd3, 5'h10);
        run_slot(7, 15, 4'b1101, 8'hC0, 14, 1'b0, "f6d1c");
        run_slot(0, 15, 4'b1011, 8'hC0, 14, 1'b0, "f6d2");
        run_slot(0, 15, 4'b0111, F6_D3, 14, 1'b0, "f6d3");

        // Frame 7: both writes visible.
        run_slot(0, 15, 4'b1110, 8'hF8, 14, 1'b1, "f7d0");
        run_slot(0, 15, 4'b1101, 8'hC0, 14, 1'b0, "f7d1");
        run_slot(0, 15, 4'b1011, 8'hC0, 14, 1'b0, "f7d2");
        run_slot(0, 15, 4'b0111, 8'h40, 14, 1'b0, "f7d3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
